// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional even parity, stop bit(s).
// Parity is compiled in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 50000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_MAX        = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
  localparam int BIT_W          = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [BIT_W-1:0]        r_bit;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_txd;
  logic                    r_busy;
`ifdef UART_TX_PARITY_EN
  logic                    r_parity;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_cnt == CNT_LAST);

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      // Bit timer free-runs through every non-idle state and wraps at each bit boundary.
      if (r_state != IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (uart_tx_en) begin
            r_shift  <= uart_tx_data;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_state  <= START;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^uart_tx_data;
`endif
          end
        end
        START: begin
          if (w_bit_end) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_parity;
              r_state <= PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= STOP;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_txd   <= 1'b1;
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          // Line is already high; r_bit counts stop bits here.
          if (w_bit_end) begin
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
